// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU issue controller: ALUctr codes, MIPS
// opcode/funct values, FSM states, response exception codes and immediate selects.
package alu_pkg;

  typedef enum logic [2:0] {
    CTR_ADDU = 3'b000,
    CTR_ADD  = 3'b001,
    CTR_OR   = 3'b010,
    CTR_SUBU = 3'b100,
    CTR_SUB  = 3'b101,
    CTR_SLTU = 3'b110,
    CTR_SLT  = 3'b111
  } alu_ctr_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SLTU = 6'b101011;
  localparam logic [5:0] FN_SLT  = 6'b101010;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DECODE,
    ST_EXEC,
    ST_RESP
  } state_e;

  typedef enum logic [1:0] {
    EXC_OK  = 2'b00,
    EXC_OVF = 2'b01,
    EXC_ILL = 2'b10
  } exc_e;

  typedef enum logic [1:0] {
    IMM_NONE,
    IMM_SEXT,
    IMM_ZEXT
  } imm_sel_e;

  // Only the trapping arithmetic ops may raise an overflow exception.
  function automatic logic is_ovf_op(input alu_ctr_e ctr);
    return (ctr == CTR_ADD) || (ctr == CTR_SUB);
  endfunction

endpackage

// File: rtl/alu_decode.sv
// Combinational MIPS decoder: instruction word -> ALUctr, legality, immediate select.
// Defining ALU_ITYPE_EN adds ADDIU/SLTI/SLTIU/ORI; otherwise those opcodes are illegal.
module alu_decode
  import alu_pkg::*;
(
  input  logic [31:0] instr,
  output alu_ctr_e    ctr,
  output logic        legal,
  output imm_sel_e    imm_sel
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       unused_fields;

  assign opcode        = instr[31:26];
  assign funct         = instr[5:0];
  assign unused_fields = ^instr[25:6];

  always_comb begin
    ctr     = CTR_ADDU;
    legal   = 1'b0;
    imm_sel = IMM_NONE;
    case (opcode)
      OP_RTYPE: begin
        legal = 1'b1;
        case (funct)
          FN_ADDU: ctr = CTR_ADDU;
          FN_ADD:  ctr = CTR_ADD;
          FN_OR:   ctr = CTR_OR;
          FN_SUBU: ctr = CTR_SUBU;
          FN_SUB:  ctr = CTR_SUB;
          FN_SLTU: ctr = CTR_SLTU;
          FN_SLT:  ctr = CTR_SLT;
          default: legal = 1'b0;
        endcase
      end
`ifdef ALU_ITYPE_EN
      OP_ADDIU: begin
        ctr = CTR_ADDU; legal = 1'b1; imm_sel = IMM_SEXT;
      end
      OP_SLTI: begin
        ctr = CTR_SLT;  legal = 1'b1; imm_sel = IMM_SEXT;
      end
      OP_SLTIU: begin
        ctr = CTR_SLTU; legal = 1'b1; imm_sel = IMM_SEXT;
      end
      OP_ORI: begin
        ctr = CTR_OR;   legal = 1'b1; imm_sel = IMM_ZEXT;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller for an external MIPS ALU: accepts one request, decodes it, drives the
// ALU, captures the result and holds a response until consumed. Option: ALU_ITYPE_EN.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_instr,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [2:0]       alu_ctr,
  input  logic [31:0]      alu_result,
  input  logic             alu_overflow,
  input  logic             alu_z,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic             rsp_zero,
  output logic [1:0]       rsp_exc,
  output logic [CNT_W-1:0] op_count
);

  state_e           state_q;
  logic [31:0]      instr_q;
  logic [31:0]      opa_q;
  logic [31:0]      opb_q;
  logic [31:0]      alu_a_q;
  logic [31:0]      alu_b_q;
  logic [31:0]      alu_b_d;
  alu_ctr_e         alu_ctr_q;
  logic             req_ready_q;
  logic             rsp_valid_q;
  logic [31:0]      rsp_data_q;
  logic             rsp_zero_q;
  exc_e             rsp_exc_q;
  logic [CNT_W-1:0] op_count_q;
  logic [CNT_W-1:0] op_count_d;

  alu_ctr_e dec_ctr;
  logic     dec_legal;
  imm_sel_e dec_imm_sel;

  alu_decode u_decode (
    .instr   (instr_q),
    .ctr     (dec_ctr),
    .legal   (dec_legal),
    .imm_sel (dec_imm_sel)
  );

  always_comb begin
    alu_b_d = opb_q;
    case (dec_imm_sel)
      IMM_SEXT: alu_b_d = {{16{instr_q[15]}}, instr_q[15:0]};
      IMM_ZEXT: alu_b_d = {16'h0000, instr_q[15:0]};
      default:  alu_b_d = opb_q;
    endcase
  end

  assign op_count_d = op_count_q + CNT_W'(1);

  // rsp_valid rises one edge after entering RESP, so the response appears three
  // edges after acceptance for ALU ops and two for illegal instructions.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      instr_q     <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_ctr_q   <= CTR_ADDU;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_zero_q  <= 1'b0;
      rsp_exc_q   <= EXC_OK;
      op_count_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            instr_q     <= req_instr;
            opa_q       <= req_a;
            opb_q       <= req_b;
            req_ready_q <= 1'b0;
            state_q     <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (dec_legal) begin
            alu_a_q   <= opa_q;
            alu_b_q   <= alu_b_d;
            alu_ctr_q <= dec_ctr;
            state_q   <= ST_EXEC;
          end else begin
            rsp_data_q <= '0;
            rsp_zero_q <= 1'b0;
            rsp_exc_q  <= EXC_ILL;
            state_q    <= ST_RESP;
          end
        end
        ST_EXEC: begin
          if (alu_overflow && is_ovf_op(alu_ctr_q)) begin
            rsp_data_q <= '0;
            rsp_exc_q  <= EXC_OVF;
          end else begin
            rsp_data_q <= alu_result;
            rsp_exc_q  <= EXC_OK;
          end
          rsp_zero_q <= alu_z;
          state_q    <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_valid_q && rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            op_count_q  <= op_count_d;
            state_q     <= ST_IDLE;
          end else begin
            rsp_valid_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_ctr   = alu_ctr_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_zero  = rsp_zero_q;
  assign rsp_exc   = rsp_exc_q;
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl with a behavioural external ALU; a narrow counter
// width lets the op_count wrap be exercised in a short run.
module tb_alu_issue_ctrl;

  localparam int TB_CNT_W = 4;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                req_valid;
  logic                req_ready;
  logic [31:0]         req_instr;
  logic [31:0]         req_a;
  logic [31:0]         req_b;
  logic [31:0]         alu_a;
  logic [31:0]         alu_b;
  logic [2:0]          alu_ctr;
  logic [31:0]         alu_result;
  logic                alu_overflow;
  logic                alu_z;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [31:0]         rsp_data;
  logic                rsp_zero;
  logic [1:0]          rsp_exc;
  logic [TB_CNT_W-1:0] op_count;

  int n_checks = 0;
  int n_errors = 0;
  logic force_ovf = 1'b0;

  typedef struct {
    logic        legal;
    logic [2:0]  ctr;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] data;
    logic        zero;
    logic [1:0]  exc;
  } exp_t;

  exp_t sb[$];
  logic [TB_CNT_W-1:0] cnt_exp = '0;
  logic [31:0] last_a = '0;
  logic [31:0] last_b = '0;
  logic [2:0]  last_ctr = '0;

  alu_issue_ctrl #(.CNT_W(TB_CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_instr    (req_instr),
    .req_a        (req_a),
    .req_b        (req_b),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_ctr      (alu_ctr),
    .alu_result   (alu_result),
    .alu_overflow (alu_overflow),
    .alu_z        (alu_z),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_zero     (rsp_zero),
    .rsp_exc      (rsp_exc),
    .op_count     (op_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_res(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    case (c)
      3'b000, 3'b001: return a + b;
      3'b010:         return a | b;
      3'b100, 3'b101: return a - b;
      3'b110:         return {31'b0, (a < b)};
      3'b111:         return {31'b0, ($signed(a) < $signed(b))};
      default:        return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Signed overflow of add/sub is also reported for ADDU/SUBU so the bench can see it ignored.
  function automatic logic alu_ovf(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] s;
    logic [31:0] d;
    s = a + b;
    d = a - b;
    case (c)
      3'b000, 3'b001: return (a[31] == b[31]) && (s[31] != a[31]);
      3'b100, 3'b101: return (a[31] != b[31]) && (d[31] != a[31]);
      default:        return 1'b0;
    endcase
  endfunction

  always_comb begin
    alu_result   = alu_res(alu_ctr, alu_a, alu_b);
    alu_overflow = alu_ovf(alu_ctr, alu_a, alu_b) | force_ovf;
    alu_z        = (alu_result == 32'h0);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  function automatic exp_t predict(input logic [31:0] instr, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [5:0] op;
    logic [5:0] fn;
    logic [31:0] res;
    logic ovf;
    op = instr[31:26];
    fn = instr[5:0];
    e.legal = 1'b1;
    e.ctr   = 3'b000;
    e.a     = a;
    e.b     = b;
    if (op == 6'h00) begin
      case (fn)
        6'h21: e.ctr = 3'b000;
        6'h20: e.ctr = 3'b001;
        6'h25: e.ctr = 3'b010;
        6'h23: e.ctr = 3'b100;
        6'h22: e.ctr = 3'b101;
        6'h2B: e.ctr = 3'b110;
        6'h2A: e.ctr = 3'b111;
        default: e.legal = 1'b0;
      endcase
`ifdef ALU_ITYPE_EN
    end else if (op == 6'h09) begin
      e.ctr = 3'b000; e.b = {{16{instr[15]}}, instr[15:0]};
    end else if (op == 6'h0A) begin
      e.ctr = 3'b111; e.b = {{16{instr[15]}}, instr[15:0]};
    end else if (op == 6'h0B) begin
      e.ctr = 3'b110; e.b = {{16{instr[15]}}, instr[15:0]};
    end else if (op == 6'h0D) begin
      e.ctr = 3'b010; e.b = {16'h0000, instr[15:0]};
`endif
    end else begin
      e.legal = 1'b0;
    end
    if (!e.legal) begin
      e.ctr  = last_ctr;
      e.a    = last_a;
      e.b    = last_b;
      e.data = 32'h0;
      e.zero = 1'b0;
      e.exc  = 2'b10;
    end else begin
      res    = alu_res(e.ctr, e.a, e.b);
      ovf    = alu_ovf(e.ctr, e.a, e.b) | force_ovf;
      e.zero = (res == 32'h0);
      if (ovf && (e.ctr == 3'b001 || e.ctr == 3'b101)) begin
        e.data = 32'h0;
        e.exc  = 2'b01;
      end else begin
        e.data = res;
        e.exc  = 2'b00;
      end
    end
    return e;
  endfunction

  function automatic logic [31:0] rtype(input logic [5:0] fn);
    return {6'b000000, 5'd1, 5'd2, 5'd3, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [15:0] imm);
    return {op, 5'd1, 5'd2, imm};
  endfunction

  task automatic do_op(input string name, input logic [31:0] instr, input logic [31:0] a,
                       input logic [31:0] b, input int hold);
    exp_t e;
    exp_t p;
    int lat;
    e = predict(instr, a, b);
    sb.push_back(e);
    if (e.legal) begin
      last_a   = e.a;
      last_b   = e.b;
      last_ctr = e.ctr;
    end
    @(negedge clk);
    check_eq({name, ".req_ready_idle"}, {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_instr = instr;
    req_a     = a;
    req_b     = b;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 10) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check_eq({name, ".latency"}, lat, e.legal ? 32'd3 : 32'd2);
    for (int i = 0; i < hold; i++) begin
      check_eq({name, ".hold_valid"}, {31'b0, rsp_valid}, 32'd1);
      check_eq({name, ".hold_req_ready"}, {31'b0, req_ready}, 32'd0);
      check_eq({name, ".hold_data"}, rsp_data, e.data);
      check_eq({name, ".hold_exc"}, {30'b0, rsp_exc}, {30'b0, e.exc});
      @(posedge clk);
      @(negedge clk);
    end
    p = sb.pop_front();
    check_eq({name, ".rsp_data"}, rsp_data, p.data);
    check_eq({name, ".rsp_zero"}, {31'b0, rsp_zero}, {31'b0, p.zero});
    check_eq({name, ".rsp_exc"}, {30'b0, rsp_exc}, {30'b0, p.exc});
    check_eq({name, ".alu_ctr"}, {29'b0, alu_ctr}, {29'b0, p.ctr});
    check_eq({name, ".alu_a"}, alu_a, p.a);
    check_eq({name, ".alu_b"}, alu_b, p.b);
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    cnt_exp = cnt_exp + 1'b1;
    check_eq({name, ".op_count"}, {{(32-TB_CNT_W){1'b0}}, op_count}, {{(32-TB_CNT_W){1'b0}}, cnt_exp});
    check_eq({name, ".valid_after"}, {31'b0, rsp_valid}, 32'd0);
    check_eq({name, ".ready_after"}, {31'b0, req_ready}, 32'd1);
    $display("txn %-10s instr=%08h a=%08h b=%08h -> data=%08h zero=%0d exc=%0d lat=%0d cnt=%0d",
             name, instr, a, b, p.data, p.zero, p.exc, lat, op_count);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [5:0] fns [7];
    fns[0] = 6'h21; fns[1] = 6'h20; fns[2] = 6'h25; fns[3] = 6'h23;
    fns[4] = 6'h22; fns[5] = 6'h2B; fns[6] = 6'h2A;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_instr = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst.req_ready", {31'b0, req_ready}, 32'd1);
    check_eq("rst.rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check_eq("rst.rsp_data", rsp_data, 32'd0);
    check_eq("rst.rsp_zero", {31'b0, rsp_zero}, 32'd0);
    check_eq("rst.rsp_exc", {30'b0, rsp_exc}, 32'd0);
    check_eq("rst.alu_a", alu_a, 32'd0);
    check_eq("rst.alu_b", alu_b, 32'd0);
    check_eq("rst.alu_ctr", {29'b0, alu_ctr}, 32'd0);
    check_eq("rst.op_count", {{(32-TB_CNT_W){1'b0}}, op_count}, 32'd0);
    rst_n = 1'b1;

    do_op("addu",      rtype(6'h21), 32'd5,        32'd7,        0);
    do_op("add_ovf",   rtype(6'h20), 32'h7FFFFFFF, 32'd1,        0);
    do_op("addu_wrap", rtype(6'h21), 32'h7FFFFFFF, 32'd1,        0);
    do_op("subu_zero", rtype(6'h23), 32'd5,        32'd5,        0);
    do_op("illegal3f", 32'h0000003F, 32'h1234,     32'h5678,     0);

    // Abort an operation in EXEC: no response may follow and the counter clears.
    @(negedge clk);
    req_valid = 1'b1;
    req_instr = rtype(6'h21);
    req_a     = 32'd9;
    req_b     = 32'd9;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_eq("abort.rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check_eq("abort.req_ready", {31'b0, req_ready}, 32'd1);
    check_eq("abort.op_count", {{(32-TB_CNT_W){1'b0}}, op_count}, 32'd0);
    check_eq("abort.alu_ctr", {29'b0, alu_ctr}, 32'd0);
    cnt_exp  = '0;
    last_a   = '0;
    last_b   = '0;
    last_ctr = '0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      @(negedge clk);
      check_eq("abort.no_rsp", {31'b0, rsp_valid}, 32'd0);
    end
    $display("txn abort      reset during EXEC, op_count=%0d", op_count);

    do_op("or",        rtype(6'h25), 32'hF0F00000, 32'h0000FF0F, 0);
    do_op("sub_ovf",   rtype(6'h22), 32'h7FFFFFFF, 32'hFFFFFFFF, 5);
    do_op("sub",       rtype(6'h22), 32'd10,       32'd3,        0);
    do_op("sltu",      rtype(6'h2B), 32'd1,        32'hFFFFFFFF, 0);
    do_op("slt",       rtype(6'h2A), 32'hFFFFFFFF, 32'd1,        0);
    force_ovf = 1'b1;
    do_op("or_fovf",   rtype(6'h25), 32'h0,        32'h0,        0);
    do_op("slt_fovf",  rtype(6'h2A), 32'd3,        32'd2,        0);
    do_op("sub_fovf",  rtype(6'h22), 32'd8,        32'd3,        0);
    force_ovf = 1'b0;
    do_op("addiu",     itype(6'h09, 16'h8000), 32'd1, 32'h55, 0);
    do_op("ori",       itype(6'h0D, 16'h8000), 32'd1, 32'h55, 0);
    do_op("slti",      itype(6'h0A, 16'hFFFF), 32'hFFFFFFFE, 32'h55, 0);
    do_op("sltiu",     itype(6'h0B, 16'h0004), 32'd3, 32'h55, 0);
    do_op("jump_ill",  32'h08000010, 32'd1, 32'd2, 1);
    for (int i = 0; i < 6; i++) begin
      do_op("random", rtype(fns[$urandom_range(0, 6)]), $urandom, $urandom, 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 The block SHALL have exactly one clock and one reset; reset is synchronous and active-low.
REQ-002 Parameter CNT_W, default 16, SHALL set the width of the completed-operation counter.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst_n  in  1  synchronous active-low reset.
REQ-005 req_valid  in  1  request present.
REQ-006 req_ready  out  1  controller can accept a request.
REQ-007 req_instr  in  32  MIPS instruction word.
REQ-008 req_a, req_b  in  32  operand values (rs, rt).
REQ-009 alu_a, alu_b  out  32  registered operands to the external ALU.
REQ-010 alu_ctr  out  3  registered ALUctr code to the external ALU.
REQ-011 alu_result  in  32  ALU Result; alu_overflow  in  1  ALU Overflow; alu_z  in  1  ALU Z.
REQ-012 rsp_valid  out  1  response present; rsp_ready  in  1  consumer accepts.
REQ-013 rsp_data  out  32  result; rsp_zero  out  1  captured Z; rsp_exc  out  2  00 ok, 01 overflow, 10 illegal.
REQ-014 op_count  out  CNT_W  number of responses accepted since reset.

Function
REQ-015 ALUctr encoding SHALL be: ADDU 000, ADD 001, OR 010, SUBU 100, SUB 101, SLTU 110, SLT 111; 011 is never driven.
REQ-016 FSM states SHALL be IDLE, DECODE, EXEC, RESP.
REQ-017 IDLE: req_ready=1; on req_valid, latch instr/a/b and go to DECODE; all other states: req_ready=0.
REQ-018 DECODE: opcode 000000 with funct 100001/100000/100101/100011/100010/101011/101010 maps to ADDU/ADD/OR/SUBU/SUB/SLTU/SLT; register alu_a, alu_b, alu_ctr; go to EXEC.
REQ-019 DECODE with any other opcode/funct SHALL go directly to RESP with rsp_exc=10, rsp_data=0, rsp_zero=0; alu_* unchanged.
REQ-020 EXEC: sample alu_result, alu_overflow, alu_z at the EXEC clock edge; go to RESP.
REQ-021 Overflow: if the sampled alu_overflow=1 and alu_ctr is ADD or SUB, rsp_exc=01 and rsp_data=0; otherwise rsp_exc=00 and rsp_data=alu_result.
REQ-022 alu_overflow SHALL be ignored for ADDU, SUBU, OR, SLTU, SLT.
REQ-023 RESP: rsp_valid=1; rsp_data/rsp_zero/rsp_exc stable until rsp_ready=1 is seen at a clock edge, then return to IDLE.
REQ-024 Latency: request accepted at edge N -> rsp_valid high after edge N+3 (legal) or edge N+2 (illegal).
REQ-025 Backpressure: rsp_ready low holds RESP indefinitely; no new request is accepted while held.
REQ-026 op_count SHALL increment by 1 on each rsp_valid&rsp_ready edge, including exceptions, and wrap from all-ones to 0.

Reset
REQ-027 rst_n low at a clock edge SHALL force IDLE from any state and abort any in-flight operation without a response.
REQ-028 Reset values: req_ready=1 after reset, rsp_valid=0, rsp_data=0, rsp_zero=0, rsp_exc=00, alu_a=0, alu_b=0, alu_ctr=000, op_count=0.

Configuration
REQ-029 Macro ALU_ITYPE_EN, when defined, SHALL additionally decode ADDIU 001001 (ADDU), SLTI 001010 (SLT), SLTIU 001011 (SLTU) with alu_b=sign-extended instr[15:0], and ORI 001101 (OR) with alu_b=zero-extended instr[15:0].
REQ-030 Without ALU_ITYPE_EN, these opcodes SHALL be illegal (rsp_exc=10).

Structure
REQ-031 Package alu_pkg SHALL hold the ALUctr codes, opcode/funct constants, FSM state type and rsp_exc codes.
REQ-032 Decoding SHALL live in a combinational sub-module alu_decode (instr -> ctr, legal, imm_sel); the FSM, registers and counter are in alu_issue_ctrl.

Verification
REQ-033 SUB with a=0x7FFFFFFF, b=0xFFFFFFFF, ALU model Overflow=1 -> rsp_exc=01, rsp_data=0, alu_ctr=101.
REQ-034 SLT with a=0xFFFFFFFF, b=1 -> alu_ctr=111, rsp_data=1, rsp_exc=00; rsp_valid asserted 3 edges after acceptance.
REQ-035 Instruction 0x0000003F (funct 111111) -> rsp_exc=10 after 2 edges; op_count increments by 1 on handshake.
REQ-036 rsp_ready held low 5 cycles in RESP -> outputs stable, req_ready=0, rsp_valid high throughout; released -> IDLE the next cycle.
REQ-037 rst_n low during EXEC -> IDLE next edge, rsp_valid=0, op_count=0, no response issued.
REQ-038 With ALU_ITYPE_EN, ORI imm=0x8000 -> alu_b=0x00008000; ADDIU imm=0x8000 -> alu_b=0xFFFF8000; without the macro -> rsp_exc=10.
